if_id_queue: RTL and testbench

//   Instruction queue between the fetch stage and decode. Fetch pushes {pc, instr} pairs;

---
 rtl/if_id_queue_if.sv | 47 ++++
 rtl/if_id_queue.sv | 148 ++++++++++++++
 tb/tb_if_id_queue.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/if_id_queue_if.sv
// ---------------------------------------------------------------------------
// if_id_queue_if
//   Bundles the fetch-side push channel, the decode-side pop channel, the
//   redirect flush and the queue status outputs of the fetch/decode
//   instruction queue.
//
//   Signals
//     flush              redirect: discard every queued word
//     push, push_pc,     fetch offers one {pc, instr} pair
//     push_instr
//     full               queue holds DEPTH entries (drives fetch hlt)
//     pop                decode consumes the head entry
//     valid              head entry meaningful
//     pc_out, instr_out  head entry, zero / NOP when empty
//     count              entries held, 0..DEPTH
//     err                sticky overflow / underflow indication
//
//   Modports
//     master  the fetch/decode side that drives the queue
//     slave   the queue itself
// ---------------------------------------------------------------------------
interface if_id_queue_if #(
  parameter int AW    = 2,
  parameter int WIDTH = 16
);
  logic             flush;
  logic             push;
  logic [WIDTH-1:0] push_pc;
  logic [WIDTH-1:0] push_instr;
  logic             full;
  logic             pop;
  logic             valid;
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] instr_out;
  logic [AW:0]      count;
  logic             err;

  modport master (
    output flush, push, push_pc, push_instr, pop,
    input  full, valid, pc_out, instr_out, count, err
  );

  modport slave (
    input  flush, push, push_pc, push_instr, pop,
    output full, valid, pc_out, instr_out, count, err
  );
endinterface

// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
//   Instruction queue between fetch and decode. Fetch pushes {pc, instr}
//   pairs, decode pops them in order. The head entry is presented
//   first-word-fall-through; an empty queue reads as pc 0 / NOP (16'h0000).
//   A flush (branch/jump redirect) empties the queue in one cycle.
//
//   Ports
//     clk   clock, all state updates on the rising edge
//     rst   asynchronous reset, active-high; clears pointers, count and err
//     q     if_id_queue_if.slave
//             in : flush, push, push_pc, push_instr, pop
//             out: full, valid, pc_out, instr_out, count, err
//
//   All outputs are decoded purely from registered state, so there is no
//   combinational path from push/pop/flush to any output.
// ---------------------------------------------------------------------------
module if_id_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  if_id_queue_if.slave  q
);

  localparam logic [AW:0]      FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]      ZERO_COUNT = {(AW+1){1'b0}};
  localparam logic [AW-1:0]    ZERO_PTR   = {AW{1'b0}};
  localparam logic [AW-1:0]    ONE_PTR    = AW'(1);
  localparam logic [AW:0]      ONE_COUNT  = (AW+1)'(1);
  localparam logic [WIDTH-1:0] NOP_WORD   = {WIDTH{1'b0}};

  // Storage; contents are don't-care after reset because valid gates them.
  logic [WIDTH-1:0] pc_mem_r    [DEPTH];
  logic [WIDTH-1:0] instr_mem_r [DEPTH];

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          err_r;

  logic [AW-1:0] wr_ptr_next_s;
  logic [AW-1:0] rd_ptr_next_s;
  logic [AW:0]   count_next_s;
  logic          err_next_s;

  logic          full_s;
  logic          valid_s;
  logic          push_acc_s;
  logic          pop_acc_s;
  logic          err_set_s;

  // Status decoded from the registered count only.
  always_comb begin
    full_s  = (count_r == FULL_COUNT);
    valid_s = (count_r != ZERO_COUNT);
  end

  // Accept qualification against this cycle's full/valid. A push into a full
  // queue is dropped even if a pop frees a slot in the same cycle.
  always_comb begin
    push_acc_s = q.push & ~full_s;
    pop_acc_s  = q.pop & valid_s;
    // A flush swallows the same-cycle push/pop, so neither can raise err.
    err_set_s  = ~q.flush & ((q.push & full_s) | (q.pop & ~valid_s));
  end

  // Next-state for pointers, occupancy and the sticky error flag.
  always_comb begin
    wr_ptr_next_s = wr_ptr_r;
    rd_ptr_next_s = rd_ptr_r;
    count_next_s  = count_r;
    err_next_s    = err_r | err_set_s;

    if (q.flush) begin
      wr_ptr_next_s = ZERO_PTR;
      rd_ptr_next_s = ZERO_PTR;
      count_next_s  = ZERO_COUNT;
    end else begin
      if (push_acc_s) begin
        wr_ptr_next_s = wr_ptr_r + ONE_PTR;
      end else begin
        wr_ptr_next_s = wr_ptr_r;
      end

      if (pop_acc_s) begin
        rd_ptr_next_s = rd_ptr_r + ONE_PTR;
      end else begin
        rd_ptr_next_s = rd_ptr_r;
      end

      // Simultaneous accepted push and pop leaves the occupancy unchanged.
      case ({push_acc_s, pop_acc_s})
        2'b10:   count_next_s = count_r + ONE_COUNT;
        2'b01:   count_next_s = count_r - ONE_COUNT;
        default: count_next_s = count_r;
      endcase
    end
  end

  // Control state register; async reset empties the queue immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= ZERO_PTR;
      rd_ptr_r <= ZERO_PTR;
      count_r  <= ZERO_COUNT;
      err_r    <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_next_s;
      rd_ptr_r <= rd_ptr_next_s;
      count_r  <= count_next_s;
      err_r    <= err_next_s;
    end
  end

  // Storage write; no reset needed since unread entries are masked by valid.
  always_ff @(posedge clk) begin
    if (push_acc_s && !q.flush) begin
      pc_mem_r[wr_ptr_r]    <= q.push_pc;
      instr_mem_r[wr_ptr_r] <= q.push_instr;
    end else begin
      pc_mem_r[wr_ptr_r]    <= pc_mem_r[wr_ptr_r];
      instr_mem_r[wr_ptr_r] <= instr_mem_r[wr_ptr_r];
    end
  end

  // Head presentation: first-word-fall-through, NOP when empty.
  always_comb begin
    if (valid_s) begin
      q.pc_out    = pc_mem_r[rd_ptr_r];
      q.instr_out = instr_mem_r[rd_ptr_r];
    end else begin
      q.pc_out    = NOP_WORD;
      q.instr_out = NOP_WORD;
    end
  end

  // Remaining status outputs straight from registered state.
  always_comb begin
    q.full  = full_s;
    q.valid = valid_s;
    q.count = count_r;
    q.err   = err_r;
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: hand-written vector table, directed
// flush / async-reset sequences, and a randomized run against a queue model.
module tb_if_id_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;

  if_id_queue_if #(.AW(2), .WIDTH(16)) qif ();

  if_id_queue #(.DEPTH(4), .AW(2), .WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .q   (qif)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: a plain queue of accepted {pc, instr} plus a sticky flag.
  logic [15:0] m_pc [$];
  logic [15:0] m_in [$];
  logic        m_err;

  typedef struct {
    logic        flush;
    logic        push;
    logic [15:0] pc;
    logic [15:0] instr;
    logic        pop;
    logic        e_valid;
    logic [2:0]  e_count;
    logic        e_full;
    logic [15:0] e_pc;
    logic [15:0] e_instr;
    logic        e_err;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(logic f, logic p, logic [15:0] pc, logic [15:0] ins, logic po,
                              logic v, logic [2:0] c, logic fu, logic [15:0] epc,
                              logic [15:0] eins, logic e);
    vec_t r;
    r.flush = f; r.push = p; r.pc = pc; r.instr = ins; r.pop = po;
    r.e_valid = v; r.e_count = c; r.e_full = fu; r.e_pc = epc; r.e_instr = eins; r.e_err = e;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_pc.delete();
    m_in.delete();
    m_err = 1'b0;
  endtask

  // Apply the queue rules to the model using the pre-edge occupancy.
  task automatic model_step(input logic f, input logic p, input logic [15:0] pc,
                            input logic [15:0] ins, input logic po);
    int sz;
    sz = m_pc.size();
    if (f) begin
      m_pc.delete();
      m_in.delete();
    end else begin
      if ((p && sz == 4) || (po && sz == 0)) m_err = 1'b1;
      if (po && sz != 0) begin
        void'(m_pc.pop_front());
        void'(m_in.pop_front());
      end
      if (p && sz != 4) begin
        m_pc.push_back(pc);
        m_in.push_back(ins);
      end
    end
  endtask

  task automatic chk_model(input string tag);
    int sz;
    sz = m_pc.size();
    chk({tag, ".valid"}, {31'd0, qif.valid}, {31'd0, (sz != 0)});
    chk({tag, ".count"}, {29'd0, qif.count}, sz);
    chk({tag, ".full"},  {31'd0, qif.full},  {31'd0, (sz == 4)});
    chk({tag, ".pc"},    {16'd0, qif.pc_out},    {16'd0, (sz != 0) ? m_pc[0] : 16'h0000});
    chk({tag, ".instr"}, {16'd0, qif.instr_out}, {16'd0, (sz != 0) ? m_in[0] : 16'h0000});
    chk({tag, ".err"},   {31'd0, qif.err},   {31'd0, m_err});
  endtask

  // Drive one cycle of inputs, advance the model, wait for the edge, settle.
  task automatic step(input logic f, input logic p, input logic [15:0] pc,
                      input logic [15:0] ins, input logic po);
    qif.flush = f; qif.push = p; qif.push_pc = pc; qif.push_instr = ins; qif.pop = po;
    model_step(f, p, pc, ins, po);
    @(posedge clk);
    #1;
    qif.flush = 1'b0; qif.push = 1'b0; qif.pop = 1'b0;
  endtask

  initial begin
    qif.flush = 1'b0; qif.push = 1'b0; qif.pop = 1'b0;
    qif.push_pc = 16'h0000; qif.push_instr = 16'h0000;
    model_clear();

    // Reset held, before any clock edge.
    #2;
    chk("rst.valid", {31'd0, qif.valid}, 32'd0);
    chk("rst.full",  {31'd0, qif.full},  32'd0);
    chk("rst.count", {29'd0, qif.count}, 32'd0);
    chk("rst.err",   {31'd0, qif.err},   32'd0);
    chk("rst.instr", {16'd0, qif.instr_out}, 32'd0);
    chk("rst.pc",    {16'd0, qif.pc_out},    32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Fill, overflow, drain, then concurrent push+pop with pointer wrap.
    vecs.push_back(mk(0,1,16'h0010,16'hA000,0, 1,3'd1,0,16'h0010,16'hA000,0));
    vecs.push_back(mk(0,1,16'h0011,16'hA001,0, 1,3'd2,0,16'h0010,16'hA000,0));
    vecs.push_back(mk(0,1,16'h0012,16'hA002,0, 1,3'd3,0,16'h0010,16'hA000,0));
    vecs.push_back(mk(0,1,16'h0013,16'hA003,0, 1,3'd4,1,16'h0010,16'hA000,0));
    vecs.push_back(mk(0,1,16'h0099,16'hA099,0, 1,3'd4,1,16'h0010,16'hA000,1));
    vecs.push_back(mk(0,0,16'h0000,16'h0000,1, 1,3'd3,0,16'h0011,16'hA001,1));
    vecs.push_back(mk(0,0,16'h0000,16'h0000,1, 1,3'd2,0,16'h0012,16'hA002,1));
    vecs.push_back(mk(0,0,16'h0000,16'h0000,1, 1,3'd1,0,16'h0013,16'hA003,1));
    vecs.push_back(mk(0,0,16'h0000,16'h0000,1, 0,3'd0,0,16'h0000,16'h0000,1));
    vecs.push_back(mk(0,1,16'h0100,16'hB100,0, 1,3'd1,0,16'h0100,16'hB100,1));
    vecs.push_back(mk(0,1,16'h0101,16'hB101,0, 1,3'd2,0,16'h0100,16'hB100,1));
    for (int k = 0; k < 6; k++) begin
      vecs.push_back(mk(0,1,16'h0102 + 16'(k),16'hB102 + 16'(k),1,
                        1,3'd2,0,16'h0101 + 16'(k),16'hB101 + 16'(k),1));
    end

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].flush, vecs[i].push, vecs[i].pc, vecs[i].instr, vecs[i].pop);
      chk($sformatf("vec%0d.valid", i), {31'd0, qif.valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("vec%0d.count", i), {29'd0, qif.count}, {29'd0, vecs[i].e_count});
      chk($sformatf("vec%0d.full", i),  {31'd0, qif.full},  {31'd0, vecs[i].e_full});
      chk($sformatf("vec%0d.pc", i),    {16'd0, qif.pc_out},    {16'd0, vecs[i].e_pc});
      chk($sformatf("vec%0d.instr", i), {16'd0, qif.instr_out}, {16'd0, vecs[i].e_instr});
      chk($sformatf("vec%0d.err", i),   {31'd0, qif.err},   {31'd0, vecs[i].e_err});
    end

    // Flush with same-cycle push and pop at count 3; then a fresh push.
    step(0, 1, 16'h0108, 16'hB108, 0);
    chk("pre_flush.count", {29'd0, qif.count}, 32'd3);
    step(1, 1, 16'h0050, 16'hC050, 1);
    chk("flush.count", {29'd0, qif.count}, 32'd0);
    chk("flush.valid", {31'd0, qif.valid}, 32'd0);
    chk("flush.err",   {31'd0, qif.err},   32'd1);
    chk("flush.pc",    {16'd0, qif.pc_out}, 32'd0);
    step(0, 1, 16'h0060, 16'hC060, 0);
    chk("post_flush.pc",    {16'd0, qif.pc_out},    32'h0060);
    chk("post_flush.count", {29'd0, qif.count},     32'd1);
    chk_model("post_flush");

    // Clean restart, underflow, then async reset between edges at count 2.
    rst = 1'b1; #1; rst = 1'b0;
    model_clear();
    chk("rst2.err", {31'd0, qif.err}, 32'd0);
    step(0, 0, 16'h0000, 16'h0000, 1);
    chk("underflow.err",   {31'd0, qif.err},   32'd1);
    chk("underflow.count", {29'd0, qif.count}, 32'd0);
    step(0, 1, 16'h0200, 16'hD200, 0);
    step(0, 1, 16'h0201, 16'hD201, 0);
    chk("pre_arst.count", {29'd0, qif.count}, 32'd2);
    chk("pre_arst.pc",    {16'd0, qif.pc_out}, 32'h0200);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.valid", {31'd0, qif.valid}, 32'd0);
    chk("arst.err",   {31'd0, qif.err},   32'd0);
    chk("arst.count", {29'd0, qif.count}, 32'd0);
    chk("arst.instr", {16'd0, qif.instr_out}, 32'd0);
    #1;
    rst = 1'b0;
    model_clear();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic f, p, po;
      f  = ($urandom_range(0, 19) == 0);
      p  = ($urandom_range(0, 9) < 6);
      po = ($urandom_range(0, 9) < 5);
      step(f, p, 16'($urandom), 16'($urandom), po);
      chk_model($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
